// File: rtl/backward_grad_select_pkg.sv
// Shared backward-pass definitions: state codes and the state -> gradient source map.
package backward_grad_select_pkg;

    localparam int STATE_LEN = 4;

    localparam logic [STATE_LEN-1:0] B_IDLE  = 4'd0;
    localparam logic [STATE_LEN-1:0] B_DENS  = 4'd1;
    localparam logic [STATE_LEN-1:0] B_TANH3 = 4'd2;
    localparam logic [STATE_LEN-1:0] B_TANH2 = 4'd4;
    localparam logic [STATE_LEN-1:0] B_TANH1 = 4'd6;

    localparam int SRC_IDX_W = 2;

    typedef struct packed {
        logic                 hit;
        logic [SRC_IDX_W-1:0] idx;
    } src_sel_t;

    // Only the tanh backward states consume an upstream gradient vector.
    function automatic src_sel_t state_to_src(input logic [STATE_LEN-1:0] state);
        src_sel_t r;
        r = '0;
        case (state)
            B_TANH3: begin r.hit = 1'b1; r.idx = 2'd0; end
            B_TANH2: begin r.hit = 1'b1; r.idx = 2'd1; end
            B_TANH1: begin r.hit = 1'b1; r.idx = 2'd2; end
            default: r = '0;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/backward_grad_select_if.sv
// Load request, latched vector and beat stream of the gradient selector.
interface backward_grad_select_if
    import backward_grad_select_pkg::*;
#(
    parameter int N_LEN = 16,
    parameter int ELEMS = 64,
    parameter int LANES = 8,
    parameter int N_SRC = 3,
    parameter int SH_W  = 4
);
    logic                          run;
    logic [STATE_LEN-1:0]          state;
    logic [N_SRC*ELEMS*N_LEN-1:0]  src;
    logic [SH_W-1:0]               scale_sh;
    logic                          busy;
    logic                          valid;
    logic [ELEMS*N_LEN-1:0]        q;
    logic                          out_valid;
    logic                          out_ready;
    logic [LANES*N_LEN-1:0]        out_data;
    logic                          out_last;
    logic                          done;

    modport master (
        output run, state, src, scale_sh, out_ready,
        input  busy, valid, q, out_valid, out_data, out_last, done
    );

    modport slave (
        input  run, state, src, scale_sh, out_ready,
        output busy, valid, q, out_valid, out_data, out_last, done
    );
endinterface

// File: rtl/backward_grad_select_grad_shift_lane.sv
// One element of batch scaling: arithmetic right shift, rounds toward minus infinity.
module grad_shift_lane #(
    parameter int N_LEN = 16,
    parameter int SH_W  = 4
) (
    input  logic [N_LEN-1:0] elem_i,
    input  logic [SH_W-1:0]  sh_i,
    output logic [N_LEN-1:0] elem_o
);
    // Shifts past the element width saturate to all sign bits (0 or -1).
    assign elem_o = $signed(elem_i) >>> sh_i;
endmodule

// File: rtl/backward_grad_select.sv
// Selects a gradient vector by backward state, scales it, latches it and streams it.
//
//   state  | meaning
//   IDLE   | waiting for run with a mapped backward state
//   STREAM | presenting beat k, advancing on each accepted beat
//   FLUSH  | one-cycle done pulse before accepting another run
module backward_grad_select
    import backward_grad_select_pkg::*;
#(
    parameter int N_LEN = 16,
    parameter int ELEMS = 64,
    parameter int LANES = 8,
    parameter int N_SRC = 3,
    parameter int SH_W  = 4
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    backward_grad_select_if.slave  bus
);
    localparam int BEATS = ELEMS / LANES;
    localparam int VW    = ELEMS * N_LEN;
    localparam int BW    = LANES * N_LEN;
    localparam int K_W   = (BEATS > 1) ? $clog2(BEATS) : 1;

    if (ELEMS % LANES != 0) begin : g_bad_lanes
        $error("ELEMS must be a multiple of LANES");
    end

    typedef enum logic [1:0] {IDLE = 2'd0, STREAM = 2'd1, FLUSH = 2'd2} fsm_t;

    fsm_t           fsm_q, fsm_d;
    logic [K_W-1:0] k_q, k_d;
    logic           valid_q, valid_d;
    logic [VW-1:0]  buf_q, buf_d;

    src_sel_t       sel;
    logic           hit;
    logic           last_beat;
    logic           streaming;
    logic [VW-1:0]  src_vec;
    logic [VW-1:0]  shifted;

    assign sel = state_to_src(bus.state);
    assign hit = sel.hit && (int'(sel.idx) < N_SRC);

    // Source mux; an index beyond N_SRC never loads, so it just reads zero.
    always_comb begin
        src_vec = '0;
        for (int j = 0; j < N_SRC; j++) begin
            if (int'(sel.idx) == j) src_vec = bus.src[j*VW +: VW];
        end
    end

    for (genvar i = 0; i < ELEMS; i++) begin : g_lane
        grad_shift_lane #(.N_LEN(N_LEN), .SH_W(SH_W)) u_lane (
            .elem_i (src_vec[i*N_LEN +: N_LEN]),
            .sh_i   (bus.scale_sh),
            .elem_o (shifted[i*N_LEN +: N_LEN])
        );
    end

    assign last_beat = (k_q == K_W'(BEATS - 1));
    assign streaming = (fsm_q == STREAM);

    // Next state: load in IDLE, step beats on handshake, single FLUSH cycle.
    always_comb begin
        fsm_d   = fsm_q;
        k_d     = k_q;
        valid_d = valid_q;
        buf_d   = buf_q;
        case (fsm_q)
            IDLE: begin
                if (bus.run && hit) begin
                    buf_d   = shifted;
                    valid_d = 1'b1;
                    k_d     = '0;
                    fsm_d   = STREAM;
                end
            end
            STREAM: begin
                if (bus.out_ready) begin
                    if (last_beat) begin
                        k_d   = '0;
                        fsm_d = FLUSH;
                    end else begin
                        k_d = k_q + 1'b1;
                    end
                end
            end
            FLUSH:   fsm_d = IDLE;
            default: fsm_d = IDLE;
        endcase
    end

    // State registers with synchronous reset; a mid-stream reset drops the stream silently.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            fsm_q   <= IDLE;
            k_q     <= '0;
            valid_q <= 1'b0;
            buf_q   <= '0;
        end else begin
            fsm_q   <= fsm_d;
            k_q     <= k_d;
            valid_q <= valid_d;
            buf_q   <= buf_d;
        end
    end

    assign bus.busy      = streaming;
    assign bus.out_valid = streaming;
    assign bus.done      = (fsm_q == FLUSH);
    assign bus.valid     = valid_q;
    assign bus.q         = buf_q;
    assign bus.out_last  = streaming && last_beat;
    assign bus.out_data  = streaming ? buf_q[int'(k_q)*BW +: BW] : '0;

endmodule

// File: doc/backward_grad_select.md
# backward_grad_select

Parametrised gradient-input selector and streamer for the backward-pass tanh layers. On `run`, it picks one of `N_SRC` upstream gradient vectors (for example, dense-layer output or a mix-layer output), chosen by the current backward `state`. It applies an optional arithmetic right-shift for batch scaling and latches the result. It then presents the full vector and also streams it `LANES` elements per beat under valid/ready, so downstream tanh/mix units of any width can consume it.

## Interface
- `N_LEN`, 16: element width in bits (two's-complement fixed point).
- `ELEMS`, 64: elements per gradient vector (`HID_DIM*HID_DIM` in the train build).
- `LANES`, 8: elements per stream beat. `ELEMS % LANES == 0` is required, checked by elaboration assertion.
- `N_SRC`, 3: number of selectable source vectors.
- `SH_W`, 4: width of the scale-shift input.
- `clk` input 1: single clock, rising edge.
- `rst` input 1: synchronous, active-high reset.
- `run` input 1: start request, single-cycle or held.
- `state` input `STATE_LEN`: backward-pass state code.
- `src` input `N_SRC*ELEMS*N_LEN`: source vectors. Source j is at `[j*ELEMS*N_LEN +: ELEMS*N_LEN]`, and element i is at offset `i*N_LEN`.
- `scale_sh` input `SH_W`: arithmetic right-shift amount applied to each element at load.
- `busy` output 1: high from load until the last beat is accepted.
- `valid` output 1: `q` holds a completed load. Stays high until the next load or reset.
- `q` output `ELEMS*N_LEN`: latched, scaled vector.
- `out_valid` output 1: stream beat valid.
- `out_ready` input 1: downstream accepts the beat.
- `out_data` output `LANES*N_LEN`: current beat.
- `out_last` output 1: marks the final beat.
- `done` output 1: one-cycle pulse after the final beat is accepted.

## Operation
- Source mapping is the package function `state_to_src(state)`, which returns an index and a hit flag:
  - `B_TANH3` → 0 (dense gradient).
  - `B_TANH2` → 1 (mix3 gradient).
  - `B_TANH1` → 2 (mix2 gradient).
  - Any other state → miss.
- FSM has three states: `IDLE`, `STREAM`, `FLUSH`.
- **IDLE**: if `run && hit`, then on that edge:
  - Each element of `buf[i]` is loaded as `$signed(src[sel][i]) >>> scale_sh`, i.e. sign-extending, round toward −∞.
  - `valid←1`, `busy←1`, beat counter `k←0`, next state `STREAM`.
  - `run` with a miss is ignored, and `valid`/`q` are unchanged.
- **STREAM**:
  - `out_valid=1` and `out_data=buf[k*LANES +: LANES]`.
  - `out_last=(k==ELEMS/LANES-1)`.
  - On `out_valid && out_ready`: `k←k+1`. On the last beat, go to `FLUSH` instead.
- **FLUSH**: for one cycle, `done=1` and `busy=0`, then return to `IDLE`.
- `run` outside `IDLE` is ignored; there is no queuing.
- A held `run` in `IDLE` after `FLUSH` starts a new load, which re-samples `state`, `src` and `scale_sh`.
- `scale_sh ≥ N_LEN` yields 0 or −1 per element, according to sign.
- `src` and `scale_sh` are sampled only at the load edge. Later changes do not affect `q` or the stream.

## Timing
- Reset values: `busy=0`, `valid=0`, `q=0`, `out_valid=0`, `out_data=0`, `out_last=0`, `done=0`, FSM=`IDLE`, `k=0`, `buf=0`.
- Load latency: `run` sampled at edge t → `q`/`valid`/`out_valid` are visible after edge t.
- Stream throughput is one beat per cycle when `out_ready=1`. With `out_ready` low, the beat is held stable, including `out_data` and `out_last`.
- With `out_ready` held high, `done` is asserted exactly `ELEMS/LANES` cycles after the load edge.
- Minimum spacing between loads is `ELEMS/LANES + 2` cycles.
- `out_data`/`out_last` are combinational from `buf` and `k`, and are 0 when `out_valid=0`. `out_ready` has no combinational path to any output.
- If `rst` is asserted mid-stream, all state returns to reset values on that edge. No `done` pulse is issued.

## Structure
- `STATE_LEN`, the `B_*` state codes and `state_to_src` live in the shared train package (`consts_train.vh`).
- FSM encoding is local to this block.
- One sub-module is natural: `grad_shift_lane`, a single-element arithmetic right-shift with sign extension, generated `ELEMS` times.

## Test plan
- Test configuration: `N_LEN=16`, `ELEMS=16`, `LANES=4`, `N_SRC=3`. Sources use the tb data files. Every check compares `q`/beats against an expected `>>>` of the selected source.
1. **Mapping.** `run` pulse with `state=B_TANH3`, `scale_sh=0` → next cycle `q==src[0]` and `valid=1`. Four beats follow with `out_ready=1`; beat 3 has `out_last=1`. `done` pulses 4 cycles after the load edge. Repeat with `B_TANH2` → `src[1]` and `B_TANH1` → `src[2]`.
2. **Scaling.** Element values `16'h8000`, `16'h0005`, `16'hFFFF` with `scale_sh=2` → `16'hE000`, `16'h0001`, `16'hFFFF`. With `scale_sh=15`, `16'h7FFF` → `16'h0000` and `16'h8001` → `16'hFFFF`.
3. **Backpressure.** Pseudo-random `out_ready` at 30% → `out_data`/`out_last` stay stable while stalled. The beat order is 0..3 with no loss or duplication, and `done` appears only after the last handshake.
4. **Ignored run.** `run` with `state=B_DENS` → `valid`/`q` unchanged and no stream. `run` with `state=B_TANH1` asserted during `STREAM` of a `B_TANH3` load → the stream data stays `src[0]`, and no second load occurs after `done`.
5. **Held run.** `run` held high for 20 cycles with `state=B_TANH2` → back-to-back loads spaced `ELEMS/LANES+2 = 6` cycles apart, and `src` changes between loads are reflected.
6. **Reset.** `rst` asserted after beat 1 is accepted → next cycle all outputs are 0, there is no `done`, and a subsequent `run` streams normally from beat 0.
